dmem_param: RTL

- Parametrised single-port synchronous data memory; the next-generation data memory for the datapath.
- Generalised in data width and depth.
- Adds per-byte write enables and a read-valid strobe.
- Adds a hardware clear engine that initialises every word after reset or on request, with a busy indication.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_clear_ctrl.sv | 54 +++++
 rtl/dmem_param.sv | 98 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for dmem_param (DMEM_OUT_REG_EN selects read latency)
package dmem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

`ifdef DMEM_OUT_REG_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    function automatic int calc_nbe(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

endpackage

// File: rtl/dmem_clear_ctrl.sv
// rtl/dmem_clear_ctrl.sv - clear engine FSM: walks every word after reset or on request
module dmem_clear_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counter wraps naturally to 0 on the final word, ready for the next clear.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        clr_we    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                clr_we  = 1'b1;
                cnt_nxt = cnt + 1'b1;
                if (&cnt) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/dmem_param.sv
// rtl/dmem_param.sv - parametrised single-port data memory with byte enables and clear engine
// Optional registered output stage under DMEM_OUT_REG_EN.
module dmem_param
    import dmem_pkg::*;
#(
    parameter int                    DATA_W  = 8,
    parameter int                    ADDR_W  = 4,
    parameter int                    BYTE_W  = 8,
    parameter logic [DATA_W-1:0]     CLR_VAL = '0,
    localparam int                   NBE     = calc_nbe(DATA_W, BYTE_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E,
    input  logic              WE,
    input  logic [NBE-1:0]    BE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DI,
    input  logic              Clr,
    output logic [DATA_W-1:0] DO,
    output logic              DValid,
    output logic              Busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              access, wr_en, rd_en;
    logic [DATA_W-1:0] rd_q;
    logic              rd_v;

    dmem_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr      (Clr),
        .busy     (Busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A Clr seen in IDLE wins over any access presented with it.
    assign access = E & ~Busy & ~Clr;
    assign wr_en  = access & WE;
    assign rd_en  = access & ~WE;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLR_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < NBE; i++) begin
                if (BE[i]) begin
                    mem[Addr][i*BYTE_W +: BYTE_W] <= DI[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
            rd_v <= 1'b0;
        end else begin
            rd_v <= rd_en;
            if (rd_en) begin
                rd_q <= mem[Addr];
            end
        end
    end

`ifdef DMEM_OUT_REG_EN
    logic [DATA_W-1:0] out_q;
    logic              out_v;

    // Not gated by Busy so a read issued just before a clear still drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            out_v <= 1'b0;
        end else begin
            out_v <= rd_v;
            if (rd_v) begin
                out_q <= rd_q;
            end
        end
    end

    assign DO     = out_q;
    assign DValid = out_v;
`else
    assign DO     = rd_q;
    assign DValid = rd_v;
`endif

endmodule
